// File: rtl/decoder_0_seq.sv
// decoder_0_seq: registered BCD-to-decimal decoder with handshake input.
// One active-low BCD code is taken per handshake. Its active-low decimal line
// is strobed for HOLD_CYC cycles, followed by an optional blanking gap.
// Codes 10..15 are rejected, flagged with a one-cycle pulse and counted.
module decoder_0_seq #(
  parameter int HOLD_CYC = 4,
  parameter int GAP_CYC  = 1,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Y_n,
  output logic [8:0]       I_n,
  output logic             out_valid,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);

  // The counter must hold the larger of the two phase lengths.
  localparam int MAX_CYC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int CNT_W   = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);
  // Counters load with length-1 and the phase ends when they reach zero.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       i_n_q, i_n_d;
  logic             out_valid_q, out_valid_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic [3:0] code_n;
  logic       code_ok;
  logic [8:0] code_lines;

  // Decode the incoming code: n = ~Y_n. Zero means "no line", 10..15 are illegal.
  always_comb begin
    code_n     = ~Y_n;
    code_ok    = (code_n <= 4'd9);
    code_lines = 9'h1FF;
    if (code_n != 4'd0 && code_ok) begin
      code_lines = ~(9'd1 << (code_n - 4'd1));
    end
  end

  // State register and registered outputs; reset aborts any strobe in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      i_n_q       <= 9'h1FF;
      out_valid_q <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      i_n_q       <= i_n_d;
      out_valid_q <= out_valid_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Next-state logic: accept in IDLE only, time the strobe and the blanking gap.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    i_n_d       = i_n_q;
    out_valid_d = out_valid_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (code_ok) begin
            state_d     = ST_DRIVE;
            cnt_d       = HOLD_LOAD;
            i_n_d       = code_lines;
            out_valid_d = 1'b1;
          end else begin
            // Rejected code: stay ready for another code on the next edge.
            err_pulse_d = 1'b1;
            if (err_cnt_q != {ERR_W{1'b1}}) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
          end
        end
      end
      ST_DRIVE: begin
        if (cnt_q == '0) begin
          i_n_d       = 9'h1FF;
          out_valid_d = 1'b0;
          if (GAP_CYC > 0) begin
            state_d = ST_GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cnt_d       = '0;
        i_n_d       = 9'h1FF;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign I_n       = i_n_q;
  assign out_valid = out_valid_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_decoder_0_seq.sv
// tb_decoder_0_seq: directed, table-driven bench for decoder_0_seq
// (HOLD_CYC=4, GAP_CYC=1, ERR_W=2).
module tb_decoder_0_seq;

  localparam int HOLD = 4;
  localparam int GAP  = 1;
  localparam int EW   = 2;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    Y_n;
  logic [8:0]    I_n;
  logic          out_valid;
  logic          err_pulse;
  logic [EW-1:0] err_cnt;

  int tests;
  int fails;

  decoder_0_seq #(.HOLD_CYC(HOLD), .GAP_CYC(GAP), .ERR_W(EW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Y_n       (Y_n),
    .I_n       (I_n),
    .out_valid (out_valid),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] y_n;
    logic [8:0] exp_i_n;
    string      name;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait until the block is ready again.
  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 20 && in_ready !== 1'b1; k++) step();
    if (in_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout waiting for in_ready, got %0b, expected 1", name, in_ready);
    end
  endtask

  // One valid transaction: accept, check the HOLD strobe, the gap, and return to ready.
  task automatic run_code(input logic [3:0] y, input logic [8:0] exp, input string name);
    wait_idle(name);
    in_valid = 1'b1;
    Y_n      = y;
    step();  // accept edge
    in_valid = 1'b0;
    Y_n      = 4'b1111;
    for (int h = 0; h < HOLD; h++) begin
      check({name, " I_n drive"}, 32'(I_n), 32'(exp));
      check({name, " out_valid drive"}, 32'(out_valid), 32'd1);
      check({name, " err_pulse drive"}, 32'(err_pulse), 32'd0);
      check({name, " in_ready drive"}, 32'(in_ready), 32'd0);
      step();
    end
    check({name, " I_n gap"}, 32'(I_n), 32'h1FF);
    check({name, " out_valid gap"}, 32'(out_valid), 32'd0);
    check({name, " in_ready gap"}, 32'(in_ready), 32'd0);
    step();
    check({name, " in_ready end"}, 32'(in_ready), 32'd1);
    check({name, " out_valid end"}, 32'(out_valid), 32'd0);
  endtask

  // Behavioural 9-line priority encoder (active-low in/out): highest active line wins.
  function automatic logic [3:0] enc_model(input logic [8:0] lines_n);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (lines_n[i] == 1'b0) n = 4'(i + 1);
    end
    return ~n;
  endfunction

  logic [3:0] bad_codes[5];
  logic [1:0] bad_exp[5];

  initial begin
    tests    = 0;
    fails    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    Y_n      = 4'b0110;

    vecs[0] = '{4'b0110, 9'h0FF, "n9"};
    vecs[1] = '{4'b1110, 9'h1FE, "n1"};
    vecs[2] = '{4'b1111, 9'h1FF, "n0"};
    vecs[3] = '{4'b1010, 9'h1EF, "n5"};

    bad_codes[0] = 4'b0000; bad_codes[1] = 4'b0001; bad_codes[2] = 4'b0101;
    bad_codes[3] = 4'b0010; bad_codes[4] = 4'b0011;
    bad_exp[0] = 2'd1; bad_exp[1] = 2'd2; bad_exp[2] = 2'd3;
    bad_exp[3] = 2'd3; bad_exp[4] = 2'd3;

    // Reset held with in_valid=1.
    repeat (3) step();
    check("rst I_n", 32'(I_n), 32'h1FF);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst err_cnt", 32'(err_cnt), 32'd0);
    check("rst err_pulse", 32'(err_pulse), 32'd0);
    in_valid = 1'b0;
    Y_n      = 4'b1111;
    #2 rst_n = 1'b1;
    step();
    check("post-rst in_ready", 32'(in_ready), 32'd1);
    check("post-rst I_n", 32'(I_n), 32'h1FF);

    // Table of valid codes.
    foreach (vecs[i]) run_code(vecs[i].y_n, vecs[i].exp_i_n, vecs[i].name);

    // Code offered during DRIVE is ignored.
    wait_idle("ignore");
    in_valid = 1'b1;
    Y_n      = 4'b0110;
    step();
    Y_n = 4'b1000;  // still valid, must not be taken while busy
    for (int h = 0; h < HOLD; h++) begin
      check("ignore I_n", 32'(I_n), 32'h0FF);
      check("ignore out_valid", 32'(out_valid), 32'd1);
      step();
    end
    in_valid = 1'b0;
    check("ignore gap I_n", 32'(I_n), 32'h1FF);
    step();
    check("ignore end in_ready", 32'(in_ready), 32'd1);
    check("ignore end I_n", 32'(I_n), 32'h1FF);

    // Back-to-back invalid codes, saturating 2-bit counter.
    wait_idle("bad");
    in_valid = 1'b1;
    Y_n      = bad_codes[0];
    for (int k = 0; k < 5; k++) begin
      step();
      if (k < 4) Y_n = bad_codes[k+1];
      else begin
        in_valid = 1'b0;
        Y_n      = 4'b1111;
      end
      check("bad err_pulse", 32'(err_pulse), 32'd1);
      check("bad err_cnt", 32'(err_cnt), 32'(bad_exp[k]));
      check("bad out_valid", 32'(out_valid), 32'd0);
      check("bad I_n", 32'(I_n), 32'h1FF);
      check("bad in_ready", 32'(in_ready), 32'd1);
    end
    step();
    check("bad pulse end", 32'(err_pulse), 32'd0);
    check("bad cnt hold", 32'(err_cnt), 32'd3);

    // Round trip through the encoder model; lower lines also pulled low to exercise priority.
    for (int k = 0; k < 10; k++) begin
      logic [8:0] onehot;
      logic [8:0] pat;
      logic [8:0] exp;
      onehot = (k == 0) ? 9'h000 : (9'd1 << (k - 1));
      pat    = ~(onehot | ((onehot - 9'd1) & 9'h0AA));
      if (k == 0) pat = 9'h1FF;
      exp    = ~onehot;
      run_code(enc_model(pat), exp, "roundtrip");
    end
    check("roundtrip err_cnt", 32'(err_cnt), 32'd3);

    // Reset pulsed in the 2nd DRIVE cycle aborts at once.
    wait_idle("midrst");
    in_valid = 1'b1;
    Y_n      = 4'b1110;
    step();
    in_valid = 1'b0;
    Y_n      = 4'b1111;
    step();
    check("midrst pre I_n", 32'(I_n), 32'h1FE);
    rst_n = 1'b0;
    #1;
    check("midrst I_n", 32'(I_n), 32'h1FF);
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst err_cnt", 32'(err_cnt), 32'd0);
    step();
    rst_n = 1'b1;
    for (int h = 0; h < HOLD + 1; h++) begin
      step();
      check("midrst no resume I_n", 32'(I_n), 32'h1FF);
      check("midrst no resume out_valid", 32'(out_valid), 32'd0);
      check("midrst in_ready", 32'(in_ready), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
